// File: rtl/store_merge_unit_pkg.sv
// Shared definitions for the store merge unit: store size encodings,
// FSM state enum and a size decoder.
package store_merge_unit_pkg;

  localparam logic [2:0] FN3_SB = 3'b000;
  localparam logic [2:0] FN3_SH = 3'b001;
  localparam logic [2:0] FN3_SW = 3'b010;
  localparam logic [2:0] FN3_SD = 3'b011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MRG  = 3'd2,
    WR   = 3'd3,
    FLT  = 3'd4
  } sm_state_e;

  // Number of bytes written by a store of the given size encoding.
  function automatic logic [3:0] fn3_bytes(input logic [2:0] fn3);
    case (fn3)
      FN3_SB:  fn3_bytes = 4'd1;
      FN3_SH:  fn3_bytes = 4'd2;
      FN3_SW:  fn3_bytes = 4'd4;
      FN3_SD:  fn3_bytes = 4'd8;
      default: fn3_bytes = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// Byte-lane merge: places store data at the byte offset and fills the
// remaining lanes from the read word. Purely combinational.
module store_lane_merge
  import store_merge_unit_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  input  logic [OFFW-1:0] off,
  input  logic [2:0]      fn3,
  output logic [XLEN-1:0] merged,
  output logic [NB-1:0]   be
);

  logic [XLEN-1:0] shifted;
  logic [3:0]      nbytes;
  logic [3:0]      off4;

  assign nbytes  = fn3_bytes(fn3);
  assign off4    = 4'(off);
  // Store data is aligned in the low bytes; move it up to its lane offset.
  assign shifted = wdata << {off, 3'b000};

  for (genvar i = 0; i < NB; i++) begin : g_lane
    localparam logic [3:0] LI = 4'(i);
    assign be[i]            = (LI >= off4) && ((LI - off4) < nbytes);
    assign merged[i*8 +: 8] = be[i] ? shifted[i*8 +: 8] : rdata[i*8 +: 8];
  end

endmodule

// File: rtl/store_merge_unit.sv
// Sub-word store unit: read-modify-write for partial stores, direct write
// for full-word stores, single-cycle fault pulse for misaligned stores.
module store_merge_unit
  import store_merge_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_fn3,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  output logic              done,
  output logic              misaligned
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  sm_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        fn3_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic [XLEN-1:0]   mrg_q;
  logic [NB-1:0]     be_q;
  // MRG spans two cycles: phase 0 registers the read word, phase 1
  // registers the merged word, so the memory read path never feeds the
  // lane muxes directly.
  logic              ph_q;

  logic              accept;
  logic              bad_in;
  logic              full_in;
  logic [OFFW-1:0]   off_in;
  logic [XLEN-1:0]   lm_data;
  logic [NB-1:0]     lm_be;
  logic [ADDR_W-1:0] waddr;

  assign accept = req_valid && (state_q == IDLE);
  assign off_in = req_addr[OFFW-1:0];
  assign waddr  = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};

  // Classify the incoming request: misaligned/illegal, or a full-word store.
  always_comb begin
    bad_in  = 1'b0;
    full_in = 1'b0;
    case (req_fn3)
      FN3_SB: bad_in = 1'b0;
      FN3_SH: bad_in = off_in[0];
      FN3_SW: begin
        bad_in  = (off_in[1:0] != 2'b00);
        full_in = (XLEN == 32);
      end
      FN3_SD: begin
        bad_in  = (XLEN != 64) || (off_in != '0);
        full_in = (XLEN == 64);
      end
      default: bad_in = 1'b1;
    endcase
  end

  store_lane_merge #(.XLEN(XLEN)) u_merge (
    .rdata  (rdata_q),
    .wdata  (wdata_q),
    .off    (addr_q[OFFW-1:0]),
    .fn3    (fn3_q),
    .merged (lm_data),
    .be     (lm_be)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and output decode; outputs are pure functions of state.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    done       = 1'b0;
    misaligned = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = bad_in ? FLT : (full_in ? WR : RD);
      end
      RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = waddr;
        state_d   = MRG;
      end
      MRG: if (ph_q) state_d = WR;
      WR: begin
        mem_wr_en = 1'b1;
        done      = 1'b1;
        mem_addr  = waddr;
        mem_wdata = mrg_q;
        mem_be    = be_q;
        state_d   = IDLE;
      end
      FLT: begin
        misaligned = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, read capture and merged-word register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      fn3_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mrg_q   <= '0;
      be_q    <= '0;
      ph_q    <= 1'b0;
    end else begin
      ph_q <= (state_q == MRG) && !ph_q;
      if (accept) begin
        addr_q  <= req_addr;
        fn3_q   <= req_fn3;
        wdata_q <= req_wdata;
        if (full_in && !bad_in) begin
          mrg_q <= req_wdata;
          be_q  <= '1;
        end
      end
      if (state_q == MRG) begin
        if (!ph_q) rdata_q <= mem_rdata;
        else begin
          mrg_q <= lm_data;
          be_q  <= lm_be;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Scoreboard bench for store_merge_unit at XLEN=32 and XLEN=64.
module tb_store_merge_unit;
  import store_merge_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;

  logic [31:0] req_addr;
  logic [2:0]  req_fn3;
  logic [63:0] req_wdata;
  logic [63:0] rdval;

  logic        v32, rdy32, rd32, wr32, done32, mis32;
  logic [31:0] maddr32, rdata32, wdata32;
  logic [3:0]  be32;
  logic        v64, rdy64, rd64, wr64, done64, mis64;
  logic [31:0] maddr64;
  logic [63:0] rdata64, wdata64;
  logic [7:0]  be64;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int n_cmp = 0, n_bad = 0;
  int nrd32 = 0, nrd64 = 0, nwr32 = 0, nwr64 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: read data valid exactly one cycle after the read strobe.
  always @(posedge clk) begin
    rdata32 <= rd32 ? rdval[31:0] : 32'h0;
    rdata64 <= rd64 ? rdval : 64'h0;
  end

  store_merge_unit #(.XLEN(32), .ADDR_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .req_valid(v32), .req_ready(rdy32),
    .req_addr(req_addr), .req_fn3(req_fn3), .req_wdata(req_wdata[31:0]),
    .mem_rd_en(rd32), .mem_wr_en(wr32), .mem_addr(maddr32),
    .mem_rdata(rdata32), .mem_wdata(wdata32), .mem_be(be32),
    .done(done32), .misaligned(mis32)
  );

  store_merge_unit #(.XLEN(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .req_valid(v64), .req_ready(rdy64),
    .req_addr(req_addr), .req_fn3(req_fn3), .req_wdata(req_wdata),
    .mem_rd_en(rd64), .mem_wr_en(wr64), .mem_addr(maddr64),
    .mem_rdata(rdata64), .mem_wdata(wdata64), .mem_be(be64),
    .done(done64), .misaligned(mis64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference merge: byte-by-byte placement of the store into the read word.
  function automatic void model(input int nb, input logic [31:0] a, input logic [2:0] f,
                                input logic [63:0] wd, input logic [63:0] rd,
                                output logic [63:0] d, output logic [7:0] be);
    int sz, off;
    sz  = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : (f == 3'd2) ? 4 : 8;
    off = int'(a % 32'(nb));
    d   = rd;
    be  = '0;
    for (int b = 0; b < nb; b++) begin
      if (b >= off && b < off + sz) begin
        d[b*8 +: 8] = wd[(b-off)*8 +: 8];
        be[b]       = 1'b1;
      end
    end
    if (nb == 4) d[63:32] = '0;
  endfunction

  // Write monitor: pops the scoreboard on every write strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd32) nrd32++;
      if (rd64) nrd64++;
      if (wr32) begin
        nwr32++;
        if (q32.size() == 0) chk("wr32_unexp", {63'b0, wr32}, 64'd0);
        else begin
          e = q32.pop_front();
          chk("wr32_addr", maddr32, e.addr);
          chk("wr32_data", wdata32, e.data);
          chk("wr32_be", be32, e.be);
          chk("wr32_lat", cyc, e.cyc);
          chk("wr32_done", done32, 1);
        end
      end else if (done32 || be32 != 0 || wdata32 != 0)
        chk("wr32_idle", {done32, be32, wdata32}, 64'd0);
      if (wr64) begin
        nwr64++;
        if (q64.size() == 0) chk("wr64_unexp", {63'b0, wr64}, 64'd0);
        else begin
          e = q64.pop_front();
          chk("wr64_addr", maddr64, e.addr);
          chk("wr64_data", wdata64, e.data);
          chk("wr64_be", be64, e.be);
          chk("wr64_lat", cyc, e.cyc);
          chk("wr64_done", done64, 1);
        end
      end else if (done64 || be64 != 0 || wdata64 != 0)
        chk("wr64_idle", {done64, be64, 56'd0} | wdata64, 64'd0);
    end
  end

  task automatic store(input bit is64, input logic [31:0] a, input logic [2:0] f,
                       input logic [63:0] wd, input logic [63:0] rd,
                       input logic [63:0] ed, input logic [7:0] eb, input int lat);
    exp_t e;
    int   nrd0;
    @(negedge clk);
    chk(is64 ? "ready64" : "ready32", is64 ? rdy64 : rdy32, 1);
    nrd0      = is64 ? nrd64 : nrd32;
    req_addr  = a;
    req_fn3   = f;
    req_wdata = wd;
    rdval     = rd;
    if (is64) v64 = 1'b1; else v32 = 1'b1;
    e.addr = a & (is64 ? ~32'h7 : ~32'h3);
    e.data = ed;
    e.be   = eb;
    e.cyc  = cyc + lat;
    if (is64) q64.push_back(e); else q32.push_back(e);
    @(negedge clk);
    v32 = 1'b0; v64 = 1'b0;
    // Inputs after acceptance must not affect the write.
    req_addr  = 32'hFFFF_FFFF;
    req_fn3   = 3'b111;
    req_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
    for (int i = 0; i < 12 && (is64 ? q64.size() : q32.size()) != 0; i++) @(negedge clk);
    if ((is64 ? q64.size() : q32.size()) != 0) begin
      chk("timeout", is64 ? q64.size() : q32.size(), 0);
      if (is64) q64.delete(); else q32.delete();
    end
    chk("rd_count", (is64 ? nrd64 : nrd32) - nrd0, (lat == 1) ? 0 : 1);
  endtask

  task automatic bad_store(input bit is64, input logic [31:0] a, input logic [2:0] f);
    @(negedge clk);
    chk("mis_ready", is64 ? rdy64 : rdy32, 1);
    req_addr  = a;
    req_fn3   = f;
    req_wdata = 64'h1234;
    if (is64) v64 = 1'b1; else v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0; v64 = 1'b0;
    chk("mis_pulse", is64 ? mis64 : mis32, 1);
    chk("mis_noacc", is64 ? (rd64 | wr64) : (rd32 | wr32), 0);
    @(negedge clk);
    chk("mis_clear", is64 ? mis64 : mis32, 0);
    chk("mis_idle", is64 ? rdy64 : rdy32, 1);
  endtask

  initial begin
    logic [63:0] d, wd, rd;
    logic [7:0]  be;
    logic [31:0] a;
    logic [2:0]  f;
    int          n0;
    rst_n = 1'b0; v32 = 1'b0; v64 = 1'b0;
    req_addr = '0; req_fn3 = '0; req_wdata = '0; rdval = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready32", rdy32, 1);
    chk("rst_out32", {rd32, wr32, done32, mis32, be32, maddr32} | {36'd0, wdata32}, 0);
    chk("rst_ready64", rdy64, 1);
    chk("rst_out64", {rd64, wr64, done64, mis64, be64, maddr32 & 32'h0} | wdata64 | {32'd0, maddr64}, 0);
    rst_n = 1'b1;

    store(0, 32'h1003, FN3_SB, 64'hAB, 64'h11223344, 64'hAB223344, 8'h8, 4);
    store(0, 32'h2002, FN3_SH, 64'hBEEF, 64'h11223344, 64'hBEEF3344, 8'hC, 4);
    store(0, 32'h3000, FN3_SW, 64'hDEADBEEF, 64'h0, 64'hDEADBEEF, 8'hF, 1);
    bad_store(0, 32'h2001, FN3_SH);
    bad_store(0, 32'h3002, FN3_SW);
    bad_store(0, 32'h0000, FN3_SD);
    bad_store(0, 32'h0000, 3'b100);

    for (int k = 0; k < 6; k++) begin
      f  = 3'($urandom_range(0, 1));
      a  = 32'h4000 | (32'($urandom_range(0, 63)) << 2) |
           ((f == FN3_SB) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 1)) << 1);
      wd = {$urandom, $urandom};
      rd = {32'h0, $urandom};
      model(4, a, f, wd, rd, d, be);
      store(0, a, f, wd, rd, d, be, 4);
    end

    store(1, 32'h8, FN3_SD, 64'h0123456789ABCDEF, 64'h0, 64'h0123456789ABCDEF, 8'hFF, 1);
    store(1, 32'hD, FN3_SB, 64'h5A, 64'h0102030405060708, 64'h01025A0405060708, 8'h20, 4);
    bad_store(1, 32'h12, FN3_SW);
    bad_store(1, 32'h14, FN3_SD);
    for (int k = 0; k < 4; k++) begin
      f  = 3'($urandom_range(0, 2));
      a  = 32'h6000 | (32'($urandom_range(0, 31)) << 3) |
           ((f == FN3_SB) ? 32'($urandom_range(0, 7)) :
            (f == FN3_SH) ? 32'($urandom_range(0, 3)) << 1 : 32'($urandom_range(0, 1)) << 2);
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      model(8, a, f, wd, rd, d, be);
      store(1, a, f, wd, rd, d, be, 4);
    end

    // Reset while the unit is merging: store is abandoned, no write follows.
    @(negedge clk);
    rdval = 64'h55667788; req_addr = 32'h5001; req_fn3 = FN3_SB; req_wdata = 64'h99;
    v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0;
    chk("rst_rd_seen", rd32, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstm_ready", rdy32, 1);
    chk("rstm_out", {rd32, wr32, done32, mis32}, 0);
    n0 = nwr32;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rstm_nowr", nwr32 - n0, 0);
    chk("rstm_idle", rdy32, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data-word width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  store request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port req_addr  input  ADDR_W  store byte address.
REQ-008 SHALL have port req_fn3  input  3  store size: 000 SB, 001 SH, 010 SW, 011 SD (XLEN=64 only).
REQ-009 SHALL have port req_wdata  input  XLEN  source register data; store value in the low bits.
REQ-010 SHALL have port mem_rd_en  output  1  word read strobe.
REQ-011 SHALL have port mem_wr_en  output  1  word write strobe.
REQ-012 SHALL have port mem_addr  output  ADDR_W  word-aligned address; low log2(XLEN/8) bits are zero.
REQ-013 SHALL have port mem_rdata  input  XLEN  read data, valid exactly one cycle after mem_rd_en.
REQ-014 SHALL have port mem_wdata  output  XLEN  merged write word.
REQ-015 SHALL have port mem_be  output  XLEN/8  byte lanes modified by this store.
REQ-016 SHALL have port done  output  1  one-cycle pulse, coincident with mem_wr_en.
REQ-017 SHALL have port misaligned  output  1  one-cycle fault pulse; no memory access occurs.

Function
REQ-018 SHALL implement FSM states IDLE, RD, MRG, WR, FLT.
REQ-019 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high; req_valid in other states is ignored.
REQ-020 SHALL register addr, fn3 and wdata at acceptance; later input changes have no effect.
REQ-021 SHALL go from IDLE to FLT on acceptance if the store is misaligned: SH with addr[0]=1, SW with addr[1:0]!=0, SD with addr[2:0]!=0, or fn3 not listed in REQ-008 for this XLEN.
REQ-022 SHALL go from IDLE to WR on an aligned full-word store (SW at XLEN=32, SD at XLEN=64), skipping the read.
REQ-023 SHALL go from IDLE to RD on any other aligned store.
REQ-024 SHALL in RD assert mem_rd_en with mem_addr, then go to MRG.
REQ-025 SHALL in MRG capture mem_rdata and form the merged word, then go to WR.
REQ-026 SHALL in WR assert mem_wr_en, done, mem_addr, mem_wdata and mem_be for one cycle, then go to IDLE.
REQ-027 SHALL in FLT assert misaligned for one cycle, then go to IDLE.
REQ-028 SHALL place store data at byte offset off = addr mod (XLEN/8): bytes off..off+size-1 come from req_wdata low bytes; all other bytes come from the captured read word.
REQ-029 SHALL set mem_be to ones on exactly the written lanes in WR, and to zero elsewhere.
REQ-030 SHALL take latency from acceptance to done of 4 cycles for partial stores and 1 cycle for full-word stores; next acceptance is possible the cycle after done.
REQ-031 SHALL hold mem_rd_en, mem_wr_en, done and misaligned low outside their states; mem_wdata and mem_be SHALL be zero when mem_wr_en is low.

Reset
REQ-032 SHALL on rst_n low force IDLE at once, with req_ready=1 and all other outputs 0.
REQ-033 SHALL abandon an in-flight store when reset asserts in any state; no write is issued after release.

Structure
REQ-034 SHALL take fn3 encodings and the FSM state enum from the shared core package.
REQ-035 SHALL keep byte-lane merge logic in a combinational sub-module store_lane_merge, parametrised by XLEN.

Verification
REQ-036 SHALL cover: XLEN=32, SB addr 0x1003 wdata 0xAB, rdata 0x11223344 -> 4 cycles later write 0xAB223344 to addr 0x1000, be 1000, done.
REQ-037 SHALL cover: XLEN=32, SH addr 0x2002 wdata 0xBEEF, rdata 0x11223344 -> write 0xBEEF3344, be 1100.
REQ-038 SHALL cover: SW addr 0x3000 wdata 0xDEADBEEF -> no mem_rd_en; next cycle write 0xDEADBEEF, be 1111, done.
REQ-039 SHALL cover: SH addr 0x2001 -> misaligned pulse 1 cycle after acceptance; mem_rd_en and mem_wr_en stay 0.
REQ-040 SHALL cover: XLEN=64, SD addr 0x8 -> be 0xFF, and SB addr 0xD -> be 0x20.
REQ-041 SHALL cover: rst_n low while in MRG -> IDLE at once, no write, req_ready=1.
